// File: rtl/etapa_id_decode.sv
// -----------------------------------------------------------------------------
// etapa_id_decode
// Instruction Decode stage of the MIPS pipeline. Holds the IF/ID latch and the
// 32x32 general-purpose register bank, and splits the latched instruction into
// its fields. After a soft reset the register bank is cleared one entry per
// clock; o_reset_ack rises once every register has been zeroed.
//
// Ports:
//   i_clock          system clock, all logic on the rising edge
//   i_soft_reset     synchronous, active-low reset
//   i_enable         pipeline advance enable (run/step)
//   i_stall          hold the IF/ID latch (hazard)
//   i_flush          replace the latched instruction with a bubble
//   i_instruction    instruction from fetch
//   i_pc_plus_4      PC+4 from fetch
//   i_reg_write      write-back enable
//   i_write_addr     write-back register index
//   i_write_data     write-back data
//   i_debug_addr     debug read index
//   o_valid          latched instruction is valid
//   o_pc_plus_4      latched PC+4
//   o_opcode .. o_funct  instruction fields of the latched instruction
//   o_immediate      sign-extended instr[15:0]
//   o_rs_data        GPR[rs] with write-back bypass
//   o_rt_data        GPR[rt] with write-back bypass
//   o_debug_data     GPR[i_debug_addr], committed state only
//   o_reset_ack      register bank cleared, stage ready
// -----------------------------------------------------------------------------
module etapa_id_decode #(
  parameter int LONGITUD_INSTRUCCION = 32,
  parameter int CANT_BITS_ADDR       = 10,
  parameter int CANT_REGISTROS       = 32,
  parameter int REG_ADDR_LENGTH      = 5
) (
  input  logic                            i_clock,
  input  logic                            i_soft_reset,
  input  logic                            i_enable,
  input  logic                            i_stall,
  input  logic                            i_flush,
  input  logic [LONGITUD_INSTRUCCION-1:0] i_instruction,
  input  logic [CANT_BITS_ADDR-1:0]       i_pc_plus_4,
  input  logic                            i_reg_write,
  input  logic [REG_ADDR_LENGTH-1:0]      i_write_addr,
  input  logic [LONGITUD_INSTRUCCION-1:0] i_write_data,
  input  logic [REG_ADDR_LENGTH-1:0]      i_debug_addr,
  output logic                            o_valid,
  output logic [CANT_BITS_ADDR-1:0]       o_pc_plus_4,
  output logic [5:0]                      o_opcode,
  output logic [4:0]                      o_rs,
  output logic [4:0]                      o_rt,
  output logic [4:0]                      o_rd,
  output logic [4:0]                      o_shamt,
  output logic [5:0]                      o_funct,
  output logic [LONGITUD_INSTRUCCION-1:0] o_immediate,
  output logic [LONGITUD_INSTRUCCION-1:0] o_rs_data,
  output logic [LONGITUD_INSTRUCCION-1:0] o_rt_data,
  output logic [LONGITUD_INSTRUCCION-1:0] o_debug_data,
  output logic                            o_reset_ack
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [REG_ADDR_LENGTH-1:0] LAST_REG = REG_ADDR_LENGTH'(CANT_REGISTROS - 1);

  state_t                            state_reg, state_next;
  logic [REG_ADDR_LENGTH-1:0]        cnt_reg, cnt_next;
  logic                              ack_reg, ack_next;
  logic                              clear_we;

  logic [LONGITUD_INSTRUCCION-1:0]   instr_reg;
  logic [CANT_BITS_ADDR-1:0]         pc_reg;
  logic                              valid_reg;

  logic [LONGITUD_INSTRUCCION-1:0]   gpr [CANT_REGISTROS];
  logic                              wb_en;

  // ---------------------------------------------------------------------------
  // Clear / ready FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = ack_reg;
    clear_we   = 1'b0;
    case (state_reg)
      CLEAR: begin
        clear_we = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_REG) begin
          state_next = READY;
          ack_next   = 1'b1;
        end
      end
      READY: begin
        ack_next = 1'b1;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  assign o_reset_ack = ack_reg;

  // ---------------------------------------------------------------------------
  // IF/ID latch: flush beats stall beats capture, all gated by i_enable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      instr_reg <= '0;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (state_reg == READY && i_enable) begin
      if (i_flush) begin
        instr_reg <= '0;
        valid_reg <= 1'b0;
      end else if (!i_stall) begin
        instr_reg <= i_instruction;
        pc_reg    <= i_pc_plus_4;
        valid_reg <= 1'b1;
      end
    end
  end

  assign o_valid     = valid_reg;
  assign o_pc_plus_4 = pc_reg;
  assign o_opcode    = instr_reg[31:26];
  assign o_rs        = instr_reg[25:21];
  assign o_rt        = instr_reg[20:16];
  assign o_rd        = instr_reg[15:11];
  assign o_shamt     = instr_reg[10:6];
  assign o_funct     = instr_reg[5:0];
  assign o_immediate = {{(LONGITUD_INSTRUCCION-16){instr_reg[15]}}, instr_reg[15:0]};

  // ---------------------------------------------------------------------------
  // Register bank. Reads are asynchronous, so this is a register array rather
  // than block RAM. The sequential clear and write-back share one write port;
  // write-back is only possible once the clear has finished.
  // ---------------------------------------------------------------------------
  assign wb_en = (state_reg == READY) && i_reg_write && (i_write_addr != '0);

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      if (clear_we) begin
        gpr[cnt_reg] <= '0;
      end else if (wb_en) begin
        gpr[i_write_addr] <= i_write_data;
      end
    end
  end

  // Register 0 is hard-wired to zero on every read port; the bypass lets the
  // instruction in decode see a write-back that commits on this same edge.
  always_comb begin
    o_rs_data = (o_rs == '0) ? '0 : gpr[o_rs];
    if (wb_en && (i_write_addr == o_rs)) begin
      o_rs_data = i_write_data;
    end
    o_rt_data = (o_rt == '0) ? '0 : gpr[o_rt];
    if (wb_en && (i_write_addr == o_rt)) begin
      o_rt_data = i_write_data;
    end
    o_debug_data = (i_debug_addr == '0) ? '0 : gpr[i_debug_addr];
  end

endmodule

// File: tb/tb_etapa_id_decode.sv
// -----------------------------------------------------------------------------
// tb_etapa_id_decode
// Self-checking bench for etapa_id_decode: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_etapa_id_decode;

  logic        clk = 1'b0;
  logic        i_soft_reset = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_instruction = '0;
  logic [9:0]  i_pc_plus_4 = '0;
  logic        i_reg_write = 1'b0;
  logic [4:0]  i_write_addr = '0;
  logic [31:0] i_write_data = '0;
  logic [4:0]  i_debug_addr = '0;

  logic        o_valid;
  logic [9:0]  o_pc_plus_4;
  logic [5:0]  o_opcode;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_funct;
  logic [31:0] o_immediate, o_rs_data, o_rt_data, o_debug_data;
  logic        o_reset_ack;

  always #5 clk = ~clk;

  etapa_id_decode dut (
    .i_clock       (clk),
    .i_soft_reset  (i_soft_reset),
    .i_enable      (i_enable),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_instruction (i_instruction),
    .i_pc_plus_4   (i_pc_plus_4),
    .i_reg_write   (i_reg_write),
    .i_write_addr  (i_write_addr),
    .i_write_data  (i_write_data),
    .i_debug_addr  (i_debug_addr),
    .o_valid       (o_valid),
    .o_pc_plus_4   (o_pc_plus_4),
    .o_opcode      (o_opcode),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_rd          (o_rd),
    .o_shamt       (o_shamt),
    .o_funct       (o_funct),
    .o_immediate   (o_immediate),
    .o_rs_data     (o_rs_data),
    .o_rt_data     (o_rt_data),
    .o_debug_data  (o_debug_data),
    .o_reset_ack   (o_reset_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: m_n counts clear edges since reset release (32 = ready).
  // ---------------------------------------------------------------------------
  logic [31:0] m_gpr [32];
  bit          m_known [32];
  int          m_n = 0;
  bit          m_started = 0;
  logic [31:0] m_instr = '0;
  logic [9:0]  m_pc = '0;
  bit          m_valid = 0;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (m_n == 32 && i_reg_write && i_write_addr != 0 && i_write_addr == a)
      return i_write_data;
    if (a == 0) return 32'd0;
    return m_gpr[a];
  endfunction

  function automatic bit readable(input logic [4:0] a);
    return (a == 0) || m_known[a] ||
           (m_n == 32 && i_reg_write && i_write_addr != 0 && i_write_addr == a);
  endfunction

  task automatic model_update();
    if (!i_soft_reset) begin
      m_instr = '0; m_pc = '0; m_valid = 0; m_n = 0; m_started = 1;
    end else if (m_n < 32) begin
      m_gpr[m_n] = '0; m_known[m_n] = 1; m_n++;
    end else begin
      if (i_reg_write && i_write_addr != 0) begin
        m_gpr[i_write_addr] = i_write_data; m_known[i_write_addr] = 1;
      end
      if (i_enable) begin
        if (i_flush) begin
          m_instr = '0; m_valid = 0;
        end else if (!i_stall) begin
          m_instr = i_instruction; m_pc = i_pc_plus_4; m_valid = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [4:0] rs, rt;
    if (!m_started) return;
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    chk("reset_ack", 32'(o_reset_ack), 32'(m_n == 32));
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("pc_plus_4", 32'(o_pc_plus_4), 32'(m_pc));
    chk("opcode", 32'(o_opcode), m_instr >> 26);
    chk("rs", 32'(o_rs), 32'(rs));
    chk("rt", 32'(o_rt), 32'(rt));
    chk("rd", 32'(o_rd), (m_instr >> 11) & 32'h1F);
    chk("shamt", 32'(o_shamt), (m_instr >> 6) & 32'h1F);
    chk("funct", 32'(o_funct), m_instr & 32'h3F);
    chk("immediate", o_immediate, 32'($signed(m_instr[15:0])));
    if (readable(rs)) chk("rs_data", o_rs_data, exp_read(rs));
    if (readable(rt)) chk("rt_data", o_rt_data, exp_read(rt));
    if (i_debug_addr == 0 || m_known[i_debug_addr])
      chk("debug_data", o_debug_data, (i_debug_addr == 0) ? 32'd0 : m_gpr[i_debug_addr]);
  endtask

  // Apply inputs on the falling edge and check combinational outputs there.
  task automatic drive(input bit rst, input bit en, input bit st, input bit fl,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] ins, input logic [9:0] pc, input logic [4:0] da);
    @(negedge clk);
    i_soft_reset = rst; i_enable = en; i_stall = st; i_flush = fl;
    i_reg_write = we; i_write_addr = wa; i_write_data = wd;
    i_instruction = ins; i_pc_plus_4 = pc; i_debug_addr = da;
    #1 check_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc(input bit rst, input bit en, input bit st, input bit fl,
                     input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [31:0] ins, input logic [9:0] pc, input logic [4:0] da);
    drive(rst, en, st, fl, we, wa, wd, ins, pc, da);
    edge_step();
  endtask

  initial begin
    int ack_edge;
    // Reset low two cycles, then release and watch the clear sequence.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ack_edge = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1, 1, 0, 0, 1, 5'd7, 32'hA5A5A5A5, 32'h8D09FFFC, 10'h3, 5'd0);
      if (ack_edge == 0 && o_reset_ack) ack_edge = i;
    end
    chk("ack_edge_first", 32'(ack_edge), 32'd32);

    // Reset mid-clear: write-back during clear must not stick.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 1, 5'd3, 32'hCAFEF00D, 0, 0, 5'd3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ack_edge = 0;
    for (int i = 1; i <= 34; i++) begin
      cyc(1, 0, 0, 0, 1, 5'd3, 32'hCAFEF00D, 0, 0, 5'd3);
      if (ack_edge == 0 && o_reset_ack) ack_edge = i;
      if (i <= 32) chk("valid_in_clear", 32'(o_valid), 32'd0);
    end
    chk("ack_edge_restart", 32'(ack_edge), 32'd32);
    // The last two loop edges were READY and wrote GPR[3]; reclear via reset.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0, 1, 5'd3, 32'hCAFEF00D, 0, 0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i));
      chk("debug_cleared", o_debug_data, 32'd0);
      edge_step();
    end

    // Capture lw $9, -4($8).
    cyc(1, 1, 0, 0, 0, 0, 0, 32'h8D09FFFC, 10'h004, 0);
    chk("tp_opcode", 32'(o_opcode), 32'h23);
    chk("tp_rs", 32'(o_rs), 32'd8);
    chk("tp_rt", 32'(o_rt), 32'd9);
    chk("tp_imm", o_immediate, 32'hFFFFFFFC);
    chk("tp_valid", 32'(o_valid), 32'd1);
    chk("tp_pc", 32'(o_pc_plus_4), 32'd4);

    // Bypass of GPR[8] with the latch held.
    drive(1, 0, 0, 0, 1, 5'd8, 32'h12345678, 0, 0, 5'd8);
    chk("tp_bypass", o_rs_data, 32'h12345678);
    chk("tp_debug_pre", o_debug_data, 32'd0);
    edge_step();
    chk("tp_debug_post", o_debug_data, 32'h12345678);

    // Write to register 0 is dropped.
    cyc(1, 0, 0, 0, 1, 5'd0, 32'hDEADBEEF, 0, 0, 5'd0);
    chk("tp_r0_debug", o_debug_data, 32'd0);
    cyc(1, 1, 0, 0, 0, 0, 0, 32'h8C090000, 10'h008, 5'd0);
    chk("tp_r0_rs", o_rs_data, 32'd0);

    // Stall holds; flush beats stall; disabled flush holds.
    cyc(1, 1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 10'h00C, 0);
    chk("tp_stall", o_opcode == 6'h23 && o_pc_plus_4 == 10'h008 ? 32'd1 : 32'd0, 32'd1);
    cyc(1, 1, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 10'h00C, 0);
    chk("tp_flush_valid", 32'(o_valid), 32'd0);
    chk("tp_flush_instr", 32'(o_funct) | 32'(o_opcode) | o_immediate, 32'd0);
    chk("tp_flush_pc", 32'(o_pc_plus_4), 32'h008);
    cyc(1, 1, 0, 0, 0, 0, 0, 32'h01095020, 10'h010, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 10'h014, 0);
    chk("tp_disabled_flush", 32'(o_valid), 32'd1);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      logic [4:0]  wa;
      int sel;
      ins = $urandom;
      sel = $urandom_range(0, 2);
      wa = (sel == 0) ? m_instr[25:21] : (sel == 1) ? m_instr[20:16] : 5'($urandom);
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1, wa, $urandom, ins, 10'($urandom),
          5'($urandom));
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
